// File: rtl/logic_fetch_if.sv
// Game of Life fetch stage bus: board read port,
// PE neighbourhood stream and writeback framing.
interface logic_fetch_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_PE    = 4,
  parameter int ADDR_W    = 8
);
  logic                  start_in;
  logic                  stall_in;
  logic [ADDR_W-1:0]     addr_r_out;
  logic [WORD_SIZE-1:0]  data_r_in;
  logic [9*NUM_PE-1:0]   neighbors_out;
  logic                  start_out;
  logic                  stall_out;
  logic                  done_out;

  modport master (
    input  start_in, stall_in, data_r_in,
    output addr_r_out, neighbors_out,
    output start_out, stall_out, done_out
  );

  modport slave (
    output start_in, stall_in, data_r_in,
    input  addr_r_out, neighbors_out,
    input  start_out, stall_out, done_out
  );
endinterface

// File: rtl/logic_fetch.sv
// Game of Life fetch stage: streams the board through a
// 3-row x 3-word window and emits PE neighbourhoods.
module logic_fetch #(
  parameter int BOARD_W   = 64,
  parameter int BOARD_H   = 48,
  parameter int WORD_SIZE = 16,
  parameter int NUM_PE    = 4,
  parameter int ADDR_W    =
    $clog2(BOARD_W * BOARD_H / WORD_SIZE)
) (
  input logic          clk_in,
  input logic          rst_in,
  logic_fetch_if.master bus
);
  localparam int WPR = BOARD_W / WORD_SIZE;
  localparam int KN  = WORD_SIZE / NUM_PE;
  localparam int RW  = $clog2(BOARD_H);
  localparam int CW  = $clog2(WPR + 1);
  localparam int PW  = (KN > 4) ? $clog2(KN) : 2;

  typedef enum logic [1:0] {
    IDLE, FETCH, EMIT, DONE
  } state_t;

  state_t                     state;
  logic [RW-1:0]              r;
  logic [CW-1:0]              c;
  logic [PW-1:0]              ph;
  logic                       prime;
  logic                       first;
  logic [2:0][WORD_SIZE-1:0]  wl;
  logic [2:0][WORD_SIZE-1:0]  wc;
  logic [2:0][WORD_SIZE-1:0]  wr;
  logic [ADDR_W-1:0]          addr_q;
  logic [ADDR_W-1:0]          addr_cur;
  logic [CW-1:0]              fw;
  logic                       fw_ok;
  logic [3:0]                 rok;
  logic [1:0]                 cap_ix;
  logic [WORD_SIZE-1:0]       cap;
  logic [2:0][WORD_SIZE+1:0]  ext;
  logic [9*NUM_PE-1:0]        nb;
  logic                       emit_v;

  // Word being fetched and which window rows lie on the board.
  always_comb begin
    fw     = prime ? '0 : c + 1'b1;
    fw_ok  = fw < CW'(WPR);
    rok    = {1'b0, r != RW'(BOARD_H - 1), 1'b1, r != '0};
    cap_ix = 2'(ph - 1'b1);
    cap    = (rok[cap_ix] && fw_ok) ? bus.data_r_in : '0;
  end

  // Read address for the row issued in FETCH phases 0..2.
  always_comb begin
    addr_cur = '0;
    if (state == FETCH && ph < PW'(3) &&
        rok[ph[1:0]] && fw_ok)
      addr_cur = ADDR_W'((int'(r) + int'(ph) - 1) * WPR
                         + int'(fw));
  end

  assign ext[0] = {wr[0][0], wc[0], wl[0][WORD_SIZE-1]};
  assign ext[1] = {wr[1][0], wc[1], wl[1][WORD_SIZE-1]};
  assign ext[2] = {wr[2][0], wc[2], wl[2][WORD_SIZE-1]};

  // Slice the 3x3 neighbourhood of each PE's cell.
  always_comb begin
    nb = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      nb[9*p +: 3]   = ext[0][int'(ph)*NUM_PE + p +: 3];
      nb[9*p+3 +: 3] = ext[1][int'(ph)*NUM_PE + p +: 3];
      nb[9*p+6 +: 3] = ext[2][int'(ph)*NUM_PE + p +: 3];
    end
  end

  assign emit_v            = state == EMIT && !bus.stall_in;
  assign bus.neighbors_out = emit_v ? nb : '0;
  assign bus.stall_out     = !emit_v;
  assign bus.start_out     = emit_v && first && ph == '0;
  assign bus.done_out      = state == DONE && !bus.stall_in;
  assign bus.addr_r_out    = bus.stall_in ? addr_q : addr_cur;

  // Sequencer: row/word walk, window loads, frozen on stall.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= IDLE;
      r      <= '0;
      c      <= '0;
      ph     <= '0;
      prime  <= 1'b0;
      first  <= 1'b0;
      wl     <= '0;
      wc     <= '0;
      wr     <= '0;
      addr_q <= '0;
    end else if (!bus.stall_in) begin
      addr_q <= addr_cur;
      unique case (state)
        IDLE: begin
          if (bus.start_in) begin
            state <= FETCH;
            r     <= '0;
            c     <= '0;
            ph    <= '0;
            prime <= 1'b1;
            first <= 1'b1;
            wl    <= '0;
            wc    <= '0;
            wr    <= '0;
          end
        end
        FETCH: begin
          ph <= ph + 1'b1;
          if (ph == '0) begin
            wl <= wc;
            wc <= wr;
          end else begin
            wr[cap_ix] <= cap;
          end
          if (ph == PW'(3)) begin
            ph <= '0;
            if (prime) prime <= 1'b0;
            else       state <= EMIT;
          end
        end
        EMIT: begin
          ph <= ph + 1'b1;
          if (ph == '0) first <= 1'b0;
          if (ph == PW'(KN - 1)) begin
            ph <= '0;
            if (c != CW'(WPR - 1)) begin
              c     <= c + 1'b1;
              state <= FETCH;
            end else if (r != RW'(BOARD_H - 1)) begin
              r     <= r + 1'b1;
              c     <= '0;
              prime <= 1'b1;
              wl    <= '0;
              wc    <= '0;
              wr    <= '0;
              state <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_fetch.sv
// Bench for logic_fetch: board memory model, cell-level
// neighbourhood model and per-cycle stream comparison.
module tb_logic_fetch;
  localparam int W   = 64;
  localparam int H   = 48;
  localparam int WS  = 16;
  localparam int NP  = 4;
  localparam int WPR = W / WS;
  localparam int AW  = 8;
  localparam int NV  = H * W / NP;
  localparam int ROWC = 4 * (WPR + 1) + WPR * WS / NP;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_fetch_if #(.WORD_SIZE(WS), .NUM_PE(NP),
                   .ADDR_W(AW)) bus ();

  logic_fetch #(
    .BOARD_W(W), .BOARD_H(H), .WORD_SIZE(WS),
    .NUM_PE(NP), .ADDR_W(AW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  bit         board [H][W];
  logic [8:0] got   [H][W];
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  bit mon = 1'b0;
  int nvalid, ndone, start_cyc, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] g,
                              logic [63:0] e);
    vecs++;
    if (g !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, g, e, cyc);
    end
  endfunction

  function automatic logic [WS-1:0] mem_word(
      input logic [AW-1:0] a);
    logic [WS-1:0] v;
    int row, wd;
    v = '0;
    row = int'(a) / WPR;
    wd = int'(a) % WPR;
    if (row < H)
      for (int i = 0; i < WS; i++) v[i] = board[row][wd*WS+i];
    return v;
  endfunction

  // Cell-level reference: neighbour bits, off-board dead.
  function automatic logic [8:0] model_nb(int y, int x);
    logic [8:0] v;
    int yy, xx;
    v = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        yy = y + dy;
        xx = x + dx;
        if (yy >= 0 && yy < H && xx >= 0 && xx < W)
          v[(dy+1)*3 + dx + 1] = board[yy][xx];
      end
    return v;
  endfunction

  always @(posedge clk) bus.data_r_in <= mem_word(bus.addr_r_out);

  // Valid cycle e carries cells e*NP .. e*NP+NP-1 row-major.
  always @(negedge clk) begin
    if (mon) begin
      logic [9*NP-1:0] ev;
      int row, col;
      if (bus.stall_in) begin
        chk("stall_out_in_stall", 64'(bus.stall_out), 64'd1);
        chk("start_out_in_stall", 64'(bus.start_out), 64'd0);
        chk("done_out_in_stall", 64'(bus.done_out), 64'd0);
      end
      if (bus.start_out) begin
        chk("start_when_valid", 64'(bus.stall_out), 64'd0);
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (!bus.stall_out) begin
        if (nvalid < NV) begin
          row = (nvalid * NP) / W;
          col = (nvalid * NP) % W;
          for (int p = 0; p < NP; p++) begin
            ev[9*p +: 9] = model_nb(row, col + p);
            got[row][col+p] = bus.neighbors_out[9*p +: 9];
          end
          chk("nbhd", 64'(bus.neighbors_out), 64'(ev));
          chk("start_out_first", 64'(bus.start_out),
              64'(nvalid == 0));
        end
        nvalid++;
      end
      if (bus.done_out) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
  end

  task automatic gen(input int busy, input int sa,
                     input int la, input int sb, input int lb,
                     input int exp_start, input int exp_done);
    int n;
    nvalid = 0;
    ndone = 0;
    start_cyc = -1;
    done_cyc = -1;
    mon = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    while (ndone == 0 && cyc < n + 3000) begin
      bus.stall_in = (cyc >= n + sa && cyc < n + sa + la) ||
                     (cyc >= n + sb && cyc < n + sb + lb);
      bus.start_in = busy > 0 && cyc == n + busy;
      @(posedge clk); #1;
    end
    bus.stall_in = 1'b0;
    bus.start_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    mon = 1'b0;
    chk("start_latency", 64'(start_cyc - n), 64'(exp_start));
    chk("valid_count", 64'(nvalid), 64'(NV));
    chk("done_latency", 64'(done_cyc - n), 64'(exp_done));
    chk("done_pulses", 64'(ndone), 64'd1);
  endtask

  task automatic fill(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0: board[y][x] = 1'b0;
          1: board[y][x] = (y == 1 && x == 16);
          2: board[y][x] = 1'b1;
          default: board[y][x] = 1'($urandom_range(0, 1));
        endcase
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start_in = 1'b0;
    bus.stall_in = 1'b0;
    fill(0);
    @(negedge clk);
    chk("reset_addr", 64'(bus.addr_r_out), 64'd0);
    chk("reset_nbhd", 64'(bus.neighbors_out), 64'd0);
    chk("reset_stall", 64'(bus.stall_out), 64'd1);
    chk("reset_start", 64'(bus.start_out), 64'd0);
    chk("reset_done", 64'(bus.done_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All-zero board, plus an ignored start mid-generation.
    gen(100, -10, 0, -10, 0, 9, 1 + H * ROWC);

    // Single live cell straddling the word 0/1 edge.
    fill(1);
    chk("pin_model_e", 64'(model_nb(1, 15)), 64'h020);
    chk("pin_model_s", 64'(model_nb(0, 16)), 64'h080);
    gen(0, -10, 0, -10, 0, 9, 1 + H * ROWC);
    chk("cell_1_15", 64'(got[1][15]), 64'h020);
    chk("cell_1_17", 64'(got[1][17]), 64'h008);
    chk("cell_0_16", 64'(got[0][16]), 64'h080);
    chk("cell_2_15", 64'(got[2][15]), 64'h004);
    chk("cell_1_16", 64'(got[1][16]), 64'h010);

    // All-ones board: reset mid-EMIT, then a full run.
    fill(2);
    chk("pin_model_corner", 64'(model_nb(0, 0)), 64'h1B0);
    @(posedge clk); #1;
    bus.start_in = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    while (cyc < n + 18) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_addr", 64'(bus.addr_r_out), 64'd0);
    chk("midrst_nbhd", 64'(bus.neighbors_out), 64'd0);
    chk("midrst_stall", 64'(bus.stall_out), 64'd1);
    chk("midrst_start", 64'(bus.start_out), 64'd0);
    chk("midrst_done", 64'(bus.done_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    gen(0, -10, 0, -10, 0, 9, 1 + H * ROWC);
    chk("ones_0_0", 64'(got[0][0]), 64'h1B0);
    chk("ones_47_63", 64'(got[47][63]), 64'h01B);
    chk("ones_10_31", 64'(got[10][31]), 64'h1FF);
    chk("ones_0_32", 64'(got[0][32]), 64'h1F8);

    // Random board, 2-cycle FETCH stall and 3-cycle EMIT stall.
    fill(3);
    gen(0, 6, 2, 12, 3, 11, 1 + H * ROWC + 5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule

// File: doc/logic_fetch.md
Name: logic_fetch

Overview:
Upstream feeder for the logic_writeback stage in the Game of Life update pipeline. Streams the current board out of board memory word by word and keeps a 3-row x 3-word sliding window. Emits NUM_PE 3x3 neighbourhoods per cycle to the PE array, whose next_state bits logic_writeback consumes. Also generates the start/stall framing that logic_writeback expects.

Parameters:
BOARD_W, 64, board width in cells; multiple of WORD_SIZE
BOARD_H, 48, board height in cells
WORD_SIZE, 16, cells per memory word; multiple of NUM_PE
NUM_PE, 4, neighbourhoods emitted per cycle
ADDR_W, $clog2(BOARD_W*BOARD_H/WORD_SIZE), read address width

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
start_in  input  1  begin one generation; sampled only in IDLE
stall_in  input  1  freeze request from memory arbitration
addr_r_out  output  ADDR_W  board read address, row-major (row*WPR + word), WPR=BOARD_W/WORD_SIZE
data_r_in  input  WORD_SIZE  read data, valid one cycle after its address; bit i = cell column word*WORD_SIZE+i
neighbors_out  output  9*NUM_PE  PE p uses bits [9p+8:9p]: 0 NW, 1 N, 2 NE, 3 W, 4 centre, 5 E, 6 SW, 7 S, 8 SE; PE p handles cell k*NUM_PE+p of the current word in emit cycle k
start_out  output  1  pulse on the first valid neighbourhood cycle of a generation; drives writeback start_in
stall_out  output  1  high whenever neighbors_out is not valid; drives writeback stall_in
done_out  output  1  one-cycle pulse when the generation has finished emitting

Behaviour:
- Reset: state IDLE; window cleared; addr_r_out=0, neighbors_out=0, start_out=0, done_out=0, stall_out=1.
- States: IDLE, FETCH, EMIT, DONE.
- IDLE -> FETCH on start_in. Row counter r=0, word counter c=0, window cleared.
- Window: L/C/R word registers, each holding rows r-1, r, r+1.
- FETCH, 4 active cycles:
  - On entry, shift L<=C, C<=R.
  - Issue reads for rows r-1, r, r+1 of word c+1 in cycles 0..2.
  - Capture the returning data into R in cycles 1..3.
  - Rows outside 0..BOARD_H-1, or c+1>=WPR: no read; addr_r_out=0, R row loaded with 0; timing unchanged.
- Row start: two FETCHes (loading words 0 and 1) before the first EMIT. Otherwise FETCH -> EMIT.
- EMIT: WORD_SIZE/NUM_PE active cycles for word c.
  - Neighbour bits come from C, plus bit WORD_SIZE-1 of L and bit 0 of R at word edges.
  - Off-board cells read as dead (0).
  - stall_out=0 in every active EMIT cycle.
- After EMIT: if c<WPR-1, increment c and go to FETCH. Otherwise, if r<BOARD_H-1, increment r, set c=0, clear the window and go to FETCH (row start). Otherwise go to DONE.
- DONE: done_out=1 for one cycle, then IDLE.
- Timing with no stalls:
  - Cycles per row = 4*(WPR+1) + WPR*WORD_SIZE/NUM_PE (36 at defaults).
  - start_in high in cycle N -> start_out high in cycle N+9.
  - done_out high in cycle N+1+BOARD_H*row_cycles (N+1729 at defaults).
- stall_in=1 behaviour:
  - All state, counters, window and addr_r_out hold; data_r_in is not captured.
  - stall_out=1, start_out=0, done_out=0; a pending start_out/done_out pulse is deferred to the first non-stalled cycle.
  - Memory re-reads the held address every cycle, so the capture after release is correct.
- start_in outside IDLE is ignored.
- rst_in mid-generation: immediate return to reset values; the next start_in restarts from row 0.

Test Plan:
- Reset: assert rst_in mid-EMIT -> same cycle addr_r_out=0, neighbors_out=0, stall_out=1, start_out=0; a later start_in gives start_out 9 cycles after.
- Timing, defaults, all-zero board: start_in in cycle N -> start_out only at N+9; exactly 48*16=768 cycles with stall_out=0; done_out single pulse at N+1729; neighbors_out=0 throughout.
- Word boundary, single live cell at (row 1, col 16):
  - cell (1,15) neighbourhood = 0x020 (E).
  - cell (1,17) neighbourhood = 0x008 (W).
  - cell (0,16) neighbourhood = 0x080 (S).
  - cell (2,15) neighbourhood = 0x004 (NE).
  - cell (1,16) neighbourhood = 0x010.
- All-ones board: cell (0,0) = 0x1B0; cell (47,63) = 0x01B; cell (10,31) = 0x1FF; cell (0,32) = 0x1F8.
- Stall: stall_in high 2 cycles mid-FETCH and 3 cycles mid-EMIT -> stall_out high during each stall; valid neighbourhood sequence identical to the unstalled run; done_out delayed by exactly 5 cycles.
- Busy start: pulse start_in at N+100 during a generation -> ignored; only one done_out, at N+1729.
